// File: rtl/regfile_writeback_queue.sv
// Write-back queue for the 32x32 register file. Buffers completed results in order,
// drains one per cycle onto the write port, and forwards pending values to decode.
module regfile_writeback_queue #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned PTR_W = 2,
   localparam int unsigned REG_W   = 5,
   localparam int unsigned DATA_W  = 32,
   localparam int unsigned COUNT_W = PTR_W + 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [REG_W-1:0]   in_reg,
   input  logic [DATA_W-1:0]  in_data,
   input  logic               drain_en,
   input  logic               flush,
   output logic               EnableWrite,
   output logic [REG_W-1:0]   write_reg,
   output logic [DATA_W-1:0]  write_data,
   input  logic [REG_W-1:0]   fwd_reg1,
   input  logic [REG_W-1:0]   fwd_reg2,
   output logic               fwd_hit1,
   output logic               fwd_hit2,
   output logic [DATA_W-1:0]  fwd_data1,
   output logic [DATA_W-1:0]  fwd_data2,
   output logic [COUNT_W-1:0] count
);

   typedef struct packed {
      logic [REG_W-1:0]  rd;
      logic [DATA_W-1:0] data;
   } entry_t;

   entry_t              r_mem [DEPTH];
   logic [DEPTH-1:0]    r_valid;
   logic [PTR_W-1:0]    r_head;
   logic [PTR_W-1:0]    r_tail;
   logic [COUNT_W-1:0]  r_count;
   logic                r_en;
   logic [REG_W-1:0]    r_wreg;
   logic [DATA_W-1:0]   r_wdata;

   logic                w_ready;
   logic                w_push;
   logic                w_pop;
   logic [REG_W-1:0]    w_freg  [2];
   logic [1:0]          w_hit;
   logic [DATA_W-1:0]   w_fdata [2];

   assign w_ready = (r_count != COUNT_W'(DEPTH));
   assign w_push  = in_valid & w_ready & ~flush;
   assign w_pop   = (r_count != '0) & drain_en & ~flush;

   // Payload storage; validity is tracked separately so this needs no reset.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_tail] <= '{rd: in_reg, data: in_data};
      end
   end

   // Queue control and registered write port.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= '0;
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_en    <= 1'b0;
         r_wreg  <= '0;
         r_wdata <= '0;
      end else if (flush) begin
         r_valid <= '0;
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_en    <= 1'b0;
      end else begin
         r_en <= w_pop;
         if (w_push) begin
            r_valid[r_tail] <= 1'b1;
            r_tail          <= r_tail + PTR_W'(1);
         end
         if (w_pop) begin
            r_valid[r_head] <= 1'b0;
            r_wreg          <= r_mem[r_head].rd;
            r_wdata         <= r_mem[r_head].data;
            r_head          <= r_head + PTR_W'(1);
         end
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + COUNT_W'(1);
            2'b01:   r_count <= r_count - COUNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign w_freg[0] = fwd_reg1;
   assign w_freg[1] = fwd_reg2;

   // Walk oldest to newest after the output stage so the youngest match wins.
   always_comb begin
      logic [PTR_W-1:0] v_idx;
      v_idx = '0;
      for (int p = 0; p < 2; p++) begin
         w_hit[p]   = 1'b0;
         w_fdata[p] = '0;
         if (r_en && (r_wreg == w_freg[p])) begin
            w_hit[p]   = 1'b1;
            w_fdata[p] = r_wdata;
         end
         for (int k = 0; k < DEPTH; k++) begin
            v_idx = r_head + PTR_W'(k);
            if (r_valid[v_idx] && (r_mem[v_idx].rd == w_freg[p])) begin
               w_hit[p]   = 1'b1;
               w_fdata[p] = r_mem[v_idx].data;
            end
         end
      end
   end

   assign in_ready    = w_ready;
   assign EnableWrite = r_en;
   assign write_reg   = r_wreg;
   assign write_data  = r_wdata;
   assign count       = r_count;
   assign fwd_hit1    = w_hit[0];
   assign fwd_hit2    = w_hit[1];
   assign fwd_data1   = w_fdata[0];
   assign fwd_data2   = w_fdata[1];

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Bench for regfile_writeback_queue: directed vector table, corner-case sequences,
// and randomized traffic against a queue-based reference model.
module tb_regfile_writeback_queue;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned PTR_W = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_reg;
   logic [31:0] in_data;
   logic        drain_en;
   logic        flush;
   logic        EnableWrite;
   logic [4:0]  write_reg;
   logic [31:0] write_data;
   logic [4:0]  fwd_reg1, fwd_reg2;
   logic        fwd_hit1, fwd_hit2;
   logic [31:0] fwd_data1, fwd_data2;
   logic [2:0]  count;

   regfile_writeback_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_reg(in_reg), .in_data(in_data),
      .drain_en(drain_en), .flush(flush),
      .EnableWrite(EnableWrite), .write_reg(write_reg), .write_data(write_data),
      .fwd_reg1(fwd_reg1), .fwd_reg2(fwd_reg2),
      .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
      .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
      .count(count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: a plain FIFO of pending results plus the last issued write.
   typedef struct packed {
      logic [4:0]  r;
      logic [31:0] d;
   } ent_t;
   ent_t        q[$];
   logic        m_en;
   logic [4:0]  m_reg;
   logic [31:0] m_data;

   typedef struct {
      logic v; logic [4:0] r; logic [31:0] d; logic de; logic [4:0] f1;
      logic en; logic [4:0] wr; logic [31:0] wd; logic [2:0] cnt; logic rdy;
      logic hit; logic [31:0] fd;
   } vec_t;
   vec_t tbl[19];

   function automatic vec_t mk(input logic v, input logic [4:0] r, input logic [31:0] d,
                               input logic de, input logic [4:0] f1, input logic en,
                               input logic [4:0] wr, input logic [31:0] wd, input logic [2:0] cnt,
                               input logic rdy, input logic hit, input logic [31:0] fd);
      vec_t t;
      t.v = v; t.r = r; t.d = d; t.de = de; t.f1 = f1; t.en = en; t.wr = wr; t.wd = wd;
      t.cnt = cnt; t.rdy = rdy; t.hit = hit; t.fd = fd;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic v, input logic [4:0] r, input logic [31:0] d,
                        input logic de, input logic fl, input logic [4:0] f1, input logic [4:0] f2);
      in_valid = v; in_reg = r; in_data = d; drain_en = de; flush = fl;
      fwd_reg1 = f1; fwd_reg2 = f2;
   endtask

   task automatic model_reset();
      q.delete();
      m_en = 1'b0; m_reg = '0; m_data = '0;
   endtask

   // Advance the model by one clock using the inputs currently applied.
   task automatic model_step();
      bit   push, pop;
      ent_t e;
      push = in_valid && (q.size() < DEPTH);
      pop  = drain_en && (q.size() != 0);
      if (flush) begin
         q.delete();
         m_en = 1'b0;
      end else begin
         m_en = pop;
         if (pop) begin
            e = q.pop_front();
            m_reg = e.r; m_data = e.d;
         end
         if (push) q.push_back('{r: in_reg, d: in_data});
      end
   endtask

   function automatic logic [32:0] model_fwd(input logic [4:0] r);
      logic        h;
      logic [31:0] d;
      h = 1'b0; d = '0;
      if (m_en && m_reg == r) begin h = 1'b1; d = m_data; end
      foreach (q[i]) if (q[i].r == r) begin h = 1'b1; d = q[i].d; end
      return {h, d};
   endfunction

   task automatic compare_model(input string tag);
      logic [32:0] f1, f2;
      f1 = model_fwd(fwd_reg1);
      f2 = model_fwd(fwd_reg2);
      chk({tag, ".en"},    32'(EnableWrite), 32'(m_en));
      chk({tag, ".wreg"},  32'(write_reg),   32'(m_reg));
      chk({tag, ".wdata"}, write_data,       m_data);
      chk({tag, ".count"}, 32'(count),       32'(q.size()));
      chk({tag, ".ready"}, 32'(in_ready),    32'(q.size() < DEPTH));
      chk({tag, ".hit1"},  32'(fwd_hit1),    32'(f1[32]));
      chk({tag, ".fd1"},   fwd_data1,        f1[31:0]);
      chk({tag, ".hit2"},  32'(fwd_hit2),    32'(f2[32]));
      chk({tag, ".fd2"},   fwd_data2,        f2[31:0]);
   endtask

   task automatic tick(input string tag);
      model_step();
      @(posedge clk); #1;
      compare_model(tag);
   endtask

   initial begin
      rst_n = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst.en",    32'(EnableWrite), 0);
      chk("rst.wreg",  32'(write_reg),   0);
      chk("rst.wdata", write_data,       0);
      chk("rst.count", 32'(count),       0);
      rst_n = 1'b1;
      #1;
      chk("rst.ready", 32'(in_ready), 1);

      // Single push latency, full back-pressure, same-register forwarding.
      tbl[0]  = mk(1,  9, 66, 1,  9,  0,  0,  0, 0+1, 1, 1, 66);
      tbl[1]  = mk(0,  0,  0, 1,  9,  1,  9, 66, 0, 1, 1, 66);
      tbl[2]  = mk(0,  0,  0, 1,  9,  0,  9, 66, 0, 1, 0,  0);
      tbl[3]  = mk(1,  1, 10, 0,  3,  0,  9, 66, 1, 1, 0,  0);
      tbl[4]  = mk(1,  2, 20, 0,  3,  0,  9, 66, 2, 1, 0,  0);
      tbl[5]  = mk(1,  3, 30, 0,  3,  0,  9, 66, 3, 1, 1, 30);
      tbl[6]  = mk(1,  4, 40, 0,  3,  0,  9, 66, 4, 0, 1, 30);
      tbl[7]  = mk(1,  5, 50, 0,  3,  0,  9, 66, 4, 0, 1, 30);
      tbl[8]  = mk(1,  5, 50, 1,  3,  1,  1, 10, 3, 1, 1, 30);
      tbl[9]  = mk(1,  5, 50, 1,  3,  1,  2, 20, 3, 1, 1, 30);
      tbl[10] = mk(0,  0,  0, 1,  3,  1,  3, 30, 2, 1, 1, 30);
      tbl[11] = mk(0,  0,  0, 1,  3,  1,  4, 40, 1, 1, 0,  0);
      tbl[12] = mk(0,  0,  0, 1,  3,  1,  5, 50, 0, 1, 0,  0);
      tbl[13] = mk(0,  0,  0, 1,  3,  0,  5, 50, 0, 1, 0,  0);
      tbl[14] = mk(1, 19,  5, 0, 19,  0,  5, 50, 1, 1, 1,  5);
      tbl[15] = mk(1, 19, 15, 0, 19,  0,  5, 50, 2, 1, 1, 15);
      tbl[16] = mk(0,  0,  0, 1, 19,  1, 19,  5, 1, 1, 1, 15);
      tbl[17] = mk(0,  0,  0, 1, 19,  1, 19, 15, 0, 1, 1, 15);
      tbl[18] = mk(0,  0,  0, 1, 19,  0, 19, 15, 0, 1, 0,  0);

      for (int i = 0; i < 19; i++) begin
         drive(tbl[i].v, tbl[i].r, tbl[i].d, tbl[i].de, 0, tbl[i].f1, 0);
         model_step();
         @(posedge clk); #1;
         chk($sformatf("vec%0d.en", i),    32'(EnableWrite), 32'(tbl[i].en));
         chk($sformatf("vec%0d.wreg", i),  32'(write_reg),   32'(tbl[i].wr));
         chk($sformatf("vec%0d.wdata", i), write_data,       tbl[i].wd);
         chk($sformatf("vec%0d.count", i), 32'(count),       32'(tbl[i].cnt));
         chk($sformatf("vec%0d.ready", i), 32'(in_ready),    32'(tbl[i].rdy));
         chk($sformatf("vec%0d.hit1", i),  32'(fwd_hit1),    32'(tbl[i].hit));
         chk($sformatf("vec%0d.fd1", i),   fwd_data1,        tbl[i].fd);
      end

      // Steady state at count=3 with push and pop every cycle; pointers wrap.
      for (int i = 0; i < 3; i++) begin
         drive(1, 5'(10 + i), 32'(100 + i), 0, 0, 5'(10 + i), 12);
         tick("fill3");
      end
      for (int i = 0; i < 10; i++) begin
         drive(1, 5'(13 + i), 32'(200 + i), 1, 0, 5'(11 + i), 5'(13 + i));
         tick("steady");
         chk("steady.count3", 32'(count), 3);
         chk("steady.ready",  32'(in_ready), 1);
      end
      for (int i = 0; i < 4; i++) begin
         drive(0, 0, 0, 1, 0, 22, 21);
         tick("drain");
      end

      // Flush with a coincident push: the pushed register must never be written.
      for (int i = 0; i < 3; i++) begin
         drive(1, 5'(21 + i), 32'(300 + i), 0, 0, 21, 22);
         tick("preflush");
      end
      drive(1, 20, 40, 1, 1, 20, 21);
      tick("flush");
      chk("flush.count", 32'(count), 0);
      chk("flush.en",    32'(EnableWrite), 0);
      chk("flush.hit1",  32'(fwd_hit1), 0);
      chk("flush.hit2",  32'(fwd_hit2), 0);
      for (int i = 0; i < 4; i++) begin
         drive(0, 0, 0, 1, 0, 20, 21);
         tick("postflush");
         chk("postflush.nowrite", 32'(EnableWrite), 0);
      end

      // Asynchronous reset in the middle of a drain.
      for (int i = 0; i < 3; i++) begin
         drive(1, 5'(1 + i), 32'(500 + i), 0, 0, 1, 2);
         tick("prerst");
      end
      drive(0, 0, 0, 1, 0, 1, 2);
      tick("middrain");
      chk("middrain.count2", 32'(count), 2);
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst.en",    32'(EnableWrite), 0);
      chk("arst.count", 32'(count), 0);
      chk("arst.wreg",  32'(write_reg), 0);
      chk("arst.wdata", write_data, 0);
      model_reset();
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(0, 0, 0, 1, 0, 2, 3);
         tick("postrst");
         chk("postrst.nowrite", 32'(EnableWrite), 0);
      end

      // Randomized traffic over a small register set to provoke forwarding hits.
      for (int i = 0; i < 400; i++) begin
         drive(1'($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), $urandom,
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0),
               5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
         tick("rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
